ssd_scan_mux: RTL and testbench

Time-multiplexed scanner for a 4-digit common-anode seven-segment display. It captures a 16-bit value from the pipeline (PC, register or memory word) and presents one nibble at a time on `digit_hex`, which feeds the hex-to-cathode decoder directly. It also drives the matching active-low anode select, so one shared cathode bus serves all four digits. Displayed values change only at frame boundaries, so a frame never mixes digits from two different values.

---
 rtl/ssd_scan_mux.sv | 67 ++++++
 tb/tb_ssd_scan_mux.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux: 4-digit seven-segment scanner with frame-coherent updates and leading-zero blanking
module ssd_scan_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  input  logic        enable,
  output logic [3:0]  anodes,
  output logic [3:0]  digit_hex,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GQ = CW'(GUARD);
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [15:0] shown, pending;
  logic pend_v, blz_q, wrap, bound;
  logic [3:0] blk;
  assign wrap = cnt == LAST;
  assign bound = wrap && idx == 2'd3;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      shown <= '0;
      pending <= '0;
      pend_v <= 1'b0;
      blz_q <= 1'b0;
      frame_done <= 1'b0;
    end else if (!enable) begin
      cnt <= '0;
      idx <= '0;
      frame_done <= 1'b0;
      blz_q <= blank_lz;
      shown <= load ? value : pend_v ? pending : shown;
      pend_v <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      idx <= wrap ? idx + 2'd1 : idx;
      frame_done <= bound;
      if (bound) begin
        blz_q <= blank_lz;
        shown <= load ? value : pend_v ? pending : shown;
        pend_v <= 1'b0;
      end else if (load) begin
        pending <= value;
        pend_v <= 1'b1;
      end
    end
  end
  // a digit is blanked when it and everything above it is zero
  assign blk = {blz_q && shown[15:12] == 4'd0, blz_q && shown[15:8] == 8'd0,
                blz_q && shown[15:4] == 12'd0, 1'b0};
  always_comb begin
    anodes = 4'hF;
    for (int i = 0; i < 4; i++)
      anodes[i] = !(enable && idx == 2'(i) && cnt >= GQ && !blk[i]);
  end
  assign digit_hex = shown[{idx, 2'b00} +: 4];
  assign digit_idx = idx;
endmodule

// File: tb/tb_ssd_scan_mux.sv
// tb_ssd_scan_mux: directed checks of scan order, frame-coherent loads, blanking, reset and disable
module tb_ssd_scan_mux;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, blank_lz = 1'b0, enable = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] anodes, digit_hex;
  logic [1:0] digit_idx;
  logic frame_done;
  int total = 0, bad = 0, p = 0;
  ssd_scan_mux #(.REFRESH_DIV(4), .GUARD(1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
    .enable(enable), .anodes(anodes), .digit_hex(digit_hex), .digit_idx(digit_idx),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] nib(input logic [15:0] v, input int d);
    return 4'((v >> (4 * d)) & 16'hF);
  endfunction
  function automatic logic [3:0] exp_an(input logic [15:0] v, input logic b, input int q);
    int d = (q / 4) % 4;
    logic off = b && d > 0 && (v >> (4 * d)) == 16'd0;
    return (q % 4 >= 1 && !off) ? ~(4'b0001 << d) : 4'hF;
  endfunction
  task automatic run(input int n, input logic [15:0] v, input logic b);
    for (int k = 0; k < n; k++) begin
      #1;
      chk($sformatf("hex@%0d", p), 16'(digit_hex), 16'(nib(v, (p / 4) % 4)));
      chk($sformatf("an@%0d", p), 16'(anodes), 16'(exp_an(v, b, p)));
      chk($sformatf("idx@%0d", p), 16'(digit_idx), 16'((p / 4) % 4));
      chk($sformatf("fd@%0d", p), 16'(frame_done), 16'(p > 0 && p % 16 == 0));
      @(posedge clk);
      #1;
      p++;
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", 16'(anodes), 16'hF);
    chk("rst_hex", 16'(digit_hex), 16'h0);
    chk("rst_idx", 16'(digit_idx), 16'h0);
    chk("rst_fd", 16'(frame_done), 16'h0);
    rst_n = 1'b1;
    value = 16'h1234;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    enable = 1'b1;
    p = 0;
    run(32, 16'h1234, 1'b0);
    value = 16'hAAAA; load = 1'b1;
    run(1, 16'h1234, 1'b0);
    load = 1'b0;
    run(15, 16'h1234, 1'b0);
    run(5, 16'hAAAA, 1'b0);
    value = 16'h5555; load = 1'b1;
    run(1, 16'hAAAA, 1'b0);
    load = 1'b0;
    run(10, 16'hAAAA, 1'b0);
    run(6, 16'h5555, 1'b0);
    value = 16'h1111; load = 1'b1;
    run(1, 16'h5555, 1'b0);
    load = 1'b0;
    run(8, 16'h5555, 1'b0);
    value = 16'hBEEF; load = 1'b1;
    run(1, 16'h5555, 1'b0);
    load = 1'b0;
    run(32, 16'hBEEF, 1'b0);
    blank_lz = 1'b1; value = 16'h0030; load = 1'b1;
    run(1, 16'hBEEF, 1'b0);
    load = 1'b0;
    run(15, 16'hBEEF, 1'b0);
    run(12, 16'h0030, 1'b1);
    value = 16'h0000; load = 1'b1;
    run(1, 16'h0030, 1'b1);
    load = 1'b0;
    run(3, 16'h0030, 1'b1);
    run(16, 16'h0000, 1'b1);
    blank_lz = 1'b0; value = 16'h1234; load = 1'b1;
    run(1, 16'h0000, 1'b1);
    load = 1'b0;
    run(15, 16'h0000, 1'b1);
    run(9, 16'h1234, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", 16'(anodes), 16'hF);
    chk("arst_hex", 16'(digit_hex), 16'h0);
    chk("arst_idx", 16'(digit_idx), 16'h0);
    chk("arst_fd", 16'(frame_done), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    p = 0;
    run(25, 16'h0000, 1'b0);
    enable = 1'b0;
    #1;
    chk("dis_an", 16'(anodes), 16'hF);
    value = 16'h9876; load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("dis_an", 16'(anodes), 16'hF);
      chk("dis_idx", 16'(digit_idx), 16'h0);
      chk("dis_fd", 16'(frame_done), 16'h0);
      chk("dis_hex", 16'(digit_hex), 16'h6);
      @(posedge clk);
      #1;
    end
    enable = 1'b1;
    p = 0;
    run(20, 16'h9876, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
